// File: rtl/combo_lock_ctrl_if.sv
// ---------------------------------------------------------------------------
// combo_lock_ctrl_if
//   Bundle between the button conditioning logic and the lock sequencer.
//
//   Handshake: bit_valid, clear and prog_req are single-cycle strobes with
//   no ready/backpressure. The sequencer samples them on every rising clock
//   edge. Each strobe is either acted on in that same cycle or silently
//   dropped, depending on the current state. bit_in is only meaningful
//   while bit_valid is high.
//
//   Ports (slave = sequencer view):
//     bit_valid  in   entered-bit strobe
//     bit_in     in   entered bit value
//     clear      in   abort entry / relock strobe
//     prog_req   in   enter programming mode strobe (programming builds only)
//     state_o    out  ENTRY=0 CHECK=1 OPEN=2 LOCKOUT=3 PROG=4
//     open_o     out  1 iff state_o==OPEN
//     lockout_o  out  1 iff state_o==LOCKOUT
//     entry_cnt  out  bits collected so far
//     fail_cnt   out  consecutive failed attempts
// ---------------------------------------------------------------------------
interface combo_lock_ctrl_if #(
  parameter int CODE_LEN  = 6,
  parameter int MAX_FAILS = 3
);
  localparam int CW = $clog2(CODE_LEN + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);

  logic          bit_valid;
  logic          bit_in;
  logic          clear;
  logic          prog_req;
  logic [2:0]    state_o;
  logic          open_o;
  logic          lockout_o;
  logic [CW-1:0] entry_cnt;
  logic [FW-1:0] fail_cnt;

  modport master (
    output bit_valid, bit_in, clear, prog_req,
    input  state_o, open_o, lockout_o, entry_cnt, fail_cnt
  );

  modport slave (
    input  bit_valid, bit_in, clear, prog_req,
    output state_o, open_o, lockout_o, entry_cnt, fail_cnt
  );
endinterface

// File: rtl/combo_lock_ctrl.sv
// ---------------------------------------------------------------------------
// combo_lock_ctrl
//   Sequencer for the pushbutton combination lock. It shifts entered bits in
//   MSB first and compares a full code against the stored code. It also
//   tracks consecutive failures, enforces a timed lockout and relocks
//   automatically after a timed open period.
//
//   Ports:
//     clk   in  100 Hz clock
//     rst   in  asynchronous reset, active-high
//     lk    combo_lock_ctrl_if.slave: entry strobes in, status out
//
//   Build option: define COMBO_LOCK_PROG_EN to enable reprogramming the code
//   from the OPEN state. Without it, prog_req is ignored and the code is the
//   constant CODE_RESET.
// ---------------------------------------------------------------------------
module combo_lock_ctrl #(
  parameter int                  CODE_LEN      = 6,
  parameter logic [CODE_LEN-1:0] CODE_RESET    = 6'b101011,
  parameter int                  MAX_FAILS     = 3,
  parameter int                  LOCKOUT_TICKS = 500,
  parameter int                  OPEN_TICKS    = 300
) (
  input  logic                clk,
  input  logic                rst,
  combo_lock_ctrl_if.slave    lk
);
  localparam int CW   = $clog2(CODE_LEN + 1);
  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int TMAX = (LOCKOUT_TICKS > OPEN_TICKS) ? LOCKOUT_TICKS : OPEN_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    S_ENTRY   = 3'd0,
    S_CHECK   = 3'd1,
    S_OPEN    = 3'd2,
    S_LOCKOUT = 3'd3,
    S_PROG    = 3'd4
  } state_t;

  state_t              state;
  logic [CODE_LEN-1:0] shreg;
  logic [CW-1:0]       entry_cnt;
  logic [FW-1:0]       fail_cnt;
  logic [TW-1:0]       timer;

`ifdef COMBO_LOCK_PROG_EN
  logic [CODE_LEN-1:0] code;
`else
  localparam logic [CODE_LEN-1:0] code = CODE_RESET;
  // prog_req has no function in this build.
  logic unused_prog_req;
  assign unused_prog_req = lk.prog_req;
`endif

  logic [CODE_LEN-1:0] shifted;
  logic                last_bit;

  assign shifted  = {shreg[CODE_LEN-2:0], lk.bit_in};
  // The strobe being accepted now completes the code.
  assign last_bit = (entry_cnt == CW'(CODE_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_ENTRY;
      shreg     <= '0;
      entry_cnt <= '0;
      fail_cnt  <= '0;
      timer     <= '0;
`ifdef COMBO_LOCK_PROG_EN
      code      <= CODE_RESET;
`endif
    end else begin
      case (state)
        S_ENTRY: begin
          // clear has priority over a simultaneous bit strobe.
          if (lk.clear) begin
            shreg     <= '0;
            entry_cnt <= '0;
          end else if (lk.bit_valid) begin
            shreg     <= shifted;
            entry_cnt <= entry_cnt + CW'(1);
            if (last_bit) state <= S_CHECK;
          end
        end

        S_CHECK: begin
          shreg     <= '0;
          entry_cnt <= '0;
          if (shreg == code) begin
            state    <= S_OPEN;
            fail_cnt <= '0;
            timer    <= TW'(OPEN_TICKS - 1);
          end else if (fail_cnt == FW'(MAX_FAILS - 1)) begin
            state    <= S_LOCKOUT;
            fail_cnt <= FW'(MAX_FAILS);
            timer    <= TW'(LOCKOUT_TICKS - 1);
          end else begin
            state    <= S_ENTRY;
            fail_cnt <= fail_cnt + FW'(1);
          end
        end

        S_OPEN: begin
          if (lk.clear) begin
            state <= S_ENTRY;
`ifdef COMBO_LOCK_PROG_EN
          end else if (lk.prog_req) begin
            state     <= S_PROG;
            shreg     <= '0;
            entry_cnt <= '0;
`endif
          end else if (timer == '0) begin
            state <= S_ENTRY;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        S_LOCKOUT: begin
          if (timer == '0) begin
            state    <= S_ENTRY;
            fail_cnt <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end

`ifdef COMBO_LOCK_PROG_EN
        S_PROG: begin
          // Timer is left untouched (frozen) while programming.
          if (lk.clear) begin
            state     <= S_ENTRY;
            shreg     <= '0;
            entry_cnt <= '0;
          end else if (lk.bit_valid) begin
            if (last_bit) begin
              code      <= shifted;
              state     <= S_ENTRY;
              shreg     <= '0;
              entry_cnt <= '0;
            end else begin
              shreg     <= shifted;
              entry_cnt <= entry_cnt + CW'(1);
            end
          end
        end
`endif

        default: begin
          // Unused encodings (and PROG when programming is disabled).
          state     <= S_ENTRY;
          shreg     <= '0;
          entry_cnt <= '0;
        end
      endcase
    end
  end

  assign lk.state_o   = state;
  assign lk.open_o    = (state == S_OPEN);
  assign lk.lockout_o = (state == S_LOCKOUT);
  assign lk.entry_cnt = entry_cnt;
  assign lk.fail_cnt  = fail_cnt;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
module tb_combo_lock_ctrl;
  localparam int CODE_LEN      = 6;
  localparam int MAX_FAILS     = 3;
  localparam int LOCKOUT_TICKS = 500;
  localparam int OPEN_TICKS    = 300;
  localparam int CODE_RESET    = 43;   // 6'b101011
  localparam int K_FAIL = 0;
  localparam int K_OPEN = 1;
  localparam int K_LOCK = 2;
  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  combo_lock_ctrl_if #(.CODE_LEN(CODE_LEN), .MAX_FAILS(MAX_FAILS)) lk();

  combo_lock_ctrl #(
    .CODE_LEN(CODE_LEN), .CODE_RESET(6'b101011), .MAX_FAILS(MAX_FAILS),
    .LOCKOUT_TICKS(LOCKOUT_TICKS), .OPEN_TICKS(OPEN_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lk(lk)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  // reference model: stored code and consecutive failures
  int m_code  = CODE_RESET;
  int m_fails = 0;

  function automatic logic [W-1:0] pack(input int kind, input int fails, input int len);
    return {2'(kind), 2'(fails), 12'(len)};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic bv, input logic b, input logic clr, input logic pr);
    lk.bit_valid = bv;
    lk.bit_in    = b;
    lk.clear     = clr;
    lk.prog_req  = pr;
    @(negedge clk);
    lk.bit_valid = 1'b0;
    lk.bit_in    = 1'b0;
    lk.clear     = 1'b0;
    lk.prog_req  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Random strobes that the DUT must ignore in its current state.
  task automatic junk(input int n, input bit allow_clear);
    for (int i = 0; i < n; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            allow_clear ? 1'($urandom_range(0, 1)) : 1'b0,
            allow_clear ? 1'($urandom_range(0, 1)) : 1'b0);
  endtask

  task automatic wait_entry(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (lk.state_o != 3'd0 && n < 2000);
    if (lk.state_o != 3'd0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: state %0d, required 0", name, lk.state_o);
    end
  endtask

  task automatic enter_bits(input int value);
    for (int i = CODE_LEN - 1; i >= 0; i--)
      drive(1'b1, 1'(value >> i), 1'b0, 1'b0);
  endtask

  // One full code attempt. open_k==0: let the open period expire naturally;
  // otherwise clear during the open_k-th open cycle.
  task automatic attempt(input int value, input int open_k, input string tag);
    enter_bits(value);
    check({tag, "_check_state"}, int'(lk.state_o), 1);
    check({tag, "_check_cnt"}, int'(lk.entry_cnt), CODE_LEN);
    if (value == m_code) begin
      m_fails = 0;
      exp_q.push_back(pack(K_OPEN, 0, (open_k == 0) ? OPEN_TICKS : open_k));
      if (open_k == 0) begin
        junk(1 + OPEN_TICKS, 1'b0);
      end else begin
        idle(open_k);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check({tag, "_clear_relock"}, int'(lk.state_o), 0);
      end
    end else begin
      m_fails++;
      if (m_fails == MAX_FAILS) begin
        exp_q.push_back(pack(K_LOCK, MAX_FAILS, LOCKOUT_TICKS));
        m_fails = 0;
        junk(1 + LOCKOUT_TICKS, 1'b1);
      end else begin
        exp_q.push_back(pack(K_FAIL, m_fails, 0));
      end
    end
    wait_entry(tag);
    check({tag, "_fail_cnt"}, int'(lk.fail_cnt), m_fails);
    check({tag, "_entry_cnt"}, int'(lk.entry_cnt), 0);
  endtask

  // ---------------- monitor ----------------
  int  prev_state = 0;
  bit  counting   = 0;
  int  cnt_kind   = 0;
  int  cnt_fail   = 0;
  int  cnt_len    = 0;

  task automatic compare_outcome(input logic [W-1:0] got);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_outcome: got %h, required none", got);
    end else begin
      check("outcome", int'(got), int'(exp_q.pop_front()));
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      counting   = 0;
      prev_state = 0;
    end else begin
      check("open_decode", int'(lk.open_o), int'(lk.state_o == 3'd2));
      check("lockout_decode", int'(lk.lockout_o), int'(lk.state_o == 3'd3));
      if (counting) begin
        if ((cnt_kind == K_OPEN && lk.open_o) || (cnt_kind == K_LOCK && lk.lockout_o)) begin
          cnt_len++;
        end else begin
          compare_outcome(pack(cnt_kind, cnt_fail, cnt_len));
          counting = 0;
        end
      end
      if (prev_state == 1) begin
        if (lk.state_o == 3'd1) begin
          check("check_one_cycle", int'(lk.state_o), 0);
        end else if (lk.state_o == 3'd0) begin
          compare_outcome(pack(K_FAIL, int'(lk.fail_cnt), 0));
        end else if (lk.state_o == 3'd2 || lk.state_o == 3'd3) begin
          counting = 1;
          cnt_kind = (lk.state_o == 3'd2) ? K_OPEN : K_LOCK;
          cnt_fail = int'(lk.fail_cnt);
          cnt_len  = 1;
        end else begin
          compare_outcome(pack(3, int'(lk.fail_cnt), 0));
        end
      end
      prev_state = int'(lk.state_o);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int value;
    int ok;
    lk.bit_valid = 1'b0;
    lk.bit_in    = 1'b0;
    lk.clear     = 1'b0;
    lk.prog_req  = 1'b0;
    idle(3);
    check("rst_state", int'(lk.state_o), 0);
    check("rst_entry_cnt", int'(lk.entry_cnt), 0);
    check("rst_fail_cnt", int'(lk.fail_cnt), 0);
    check("rst_open", int'(lk.open_o), 0);
    check("rst_lockout", int'(lk.lockout_o), 0);
    rst = 1'b0;
    idle(2);

    // correct code, full open period
    attempt(CODE_RESET, 0, "t1");

    // three wrong codes -> lockout, strobes ignored throughout
    attempt(63, 0, "t2a");
    attempt(63, 0, "t2b");
    attempt(63, 0, "t2c");

    // partial entry, then clear together with a bit strobe
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("t3_partial_cnt", int'(lk.entry_cnt), 3);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("t3_clear_cnt", int'(lk.entry_cnt), 0);
    attempt(CODE_RESET, 0, "t3");

    // clear during the 10th open cycle; failures reset by a later open
    attempt(CODE_RESET, 10, "t4a");
    attempt(63, 0, "t4b");
    attempt(0, 0, "t4c");
    attempt(CODE_RESET, 1, "t4d");

    // reset in the middle of a lockout (timer at 200)
    attempt(63, 0, "t5a");
    attempt(62, 0, "t5b");
    enter_bits(61);
    check("t5_check_state", int'(lk.state_o), 1);
    idle(300);
    check("t5_in_lockout", int'(lk.lockout_o), 1);
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("t5_rst_state", int'(lk.state_o), 0);
    check("t5_rst_fail", int'(lk.fail_cnt), 0);
    check("t5_rst_lockout", int'(lk.lockout_o), 0);
    m_fails = 0;
    m_code  = CODE_RESET;
    idle(2);
    rst = 1'b0;
    idle(2);
    check("t5_after_lockout", int'(lk.lockout_o), 0);
    attempt(CODE_RESET, 4, "t5c");

`ifdef COMBO_LOCK_PROG_EN
    // reprogram to 000111
    enter_bits(CODE_RESET);
    exp_q.push_back(pack(K_OPEN, 0, 5));
    idle(5);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_prog_state", int'(lk.state_o), 4);
    enter_bits(7);
    check("t6_commit_state", int'(lk.state_o), 0);
    check("t6_commit_cnt", int'(lk.entry_cnt), 0);
    m_code = 7;
    attempt(CODE_RESET, 0, "t6a");
    attempt(7, 3, "t6b");
    // prog_req together with clear: clear wins
    enter_bits(7);
    exp_q.push_back(pack(K_OPEN, 0, 4));
    idle(4);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    check("t6_clear_wins", int'(lk.state_o), 0);
    // abort programming part way: code unchanged
    enter_bits(7);
    exp_q.push_back(pack(K_OPEN, 0, 2));
    idle(2);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("t6_abort_state", int'(lk.state_o), 0);
    attempt(7, 2, "t6c");
    // reset restores the original code
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    m_code  = CODE_RESET;
    m_fails = 0;
    idle(1);
    attempt(7, 0, "t6d");
    attempt(CODE_RESET, 3, "t6e");
`endif

    // randomized attempts
    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, CODE_LEN - 1);
        for (int i = 0; i < k; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check("rnd_partial_cnt", int'(lk.entry_cnt), k);
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        check("rnd_clear_cnt", int'(lk.entry_cnt), 0);
      end
      value = ($urandom_range(0, 2) == 0) ? m_code : $urandom_range(0, 63);
      ok    = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, OPEN_TICKS - 1);
      attempt(value, ok, "rnd");
    end

    idle(5);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
